// File: rtl/core_mem_seq_pkg.sv
// Shared types and constants for the core_mem_seq memory sequencer.
//   seq_state_t : sequencer FSM states
//   ST_*        : str_type store-size encodings (2'b1x is treated as word)
//   NOP_INSTR   : RV32I canonical NOP (addi x0,x0,0) presented while in reset
package core_mem_seq_pkg;

  typedef enum logic [2:0] {
    S_RST,
    S_F_REQ,
    S_F_WAIT,
    S_EXEC,
    S_D_REQ,
    S_D_WAIT,
    S_COMMIT
  } seq_state_t;

  localparam logic [1:0] ST_BYTE = 2'b00;
  localparam logic [1:0] ST_HALF = 2'b01;
  localparam logic [1:0] ST_WORD = 2'b10;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/core_store_lane.sv
// Store lane steering: maps store size, byte offset and right-aligned store
// data onto SRAM byte enables and replicated write data, and flags stores
// whose offset is not naturally aligned for their size.
//   str_type : 00 byte, 01 half, 1x word
//   a        : byte offset within the word (alu_out[1:0])
//   wr_d     : right-aligned store data from the core
//   be       : SRAM byte enables
//   wdata    : SRAM write data (value replicated across lanes)
//   misalign : half with a[0]=1, or word with a!=0
module core_store_lane
  import core_mem_seq_pkg::*;
(
  input  logic [1:0]  str_type,
  input  logic [1:0]  a,
  input  logic [31:0] wr_d,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misalign
);

  always_comb begin
    be       = '0;
    wdata    = '0;
    misalign = 1'b0;
    case (str_type)
      ST_BYTE: begin
        be    = 4'b0001 << a;
        wdata = {4{wr_d[7:0]}};
      end
      ST_HALF: begin
        be       = a[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{wr_d[15:0]}};
        misalign = a[0];
      end
      default: begin
        be       = '1;
        wdata    = wr_d;
        misalign = (a != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/core_mem_seq.sv
// Multi-cycle sequencer sharing one single-port, fixed-latency SRAM between
// instruction fetch and load/store of a single-cycle RV32I core.
// Per instruction: fetch nxt_instr -> present instr -> optional data access
// -> one-cycle vld retire pulse.
//
// Parameters: ADDR_W (SRAM word-address width), MEM_LAT (read latency, 1..4).
// Core side : nxt_instr, alu_out, mem_wr_d, mem_rd, mem_wr, str_type in;
//             instr, mem_rd_d, vld out.
// SRAM side : m_req, m_we, m_addr, m_wdata, m_be out; m_rdata in.
// Status    : seq_err, sticky until reset (mem_rd+mem_wr together, or a
//             misaligned store).
// Optional  : `define CORE_MEM_SEQ_PERF_EN adds instret_cnt (COMMIT cycles)
//             and mem_cyc_cnt (m_req cycles) outputs.
module core_mem_seq
  import core_mem_seq_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] nxt_instr,
  input  logic [31:0]       alu_out,
  input  logic [31:0]       mem_wr_d,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [1:0]        str_type,
  output logic [31:0]       instr,
  output logic [31:0]       mem_rd_d,
  output logic              vld,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_be,
  input  logic [31:0]       m_rdata,
  output logic              seq_err
`ifdef CORE_MEM_SEQ_PERF_EN
  ,
  output logic [31:0]       instret_cnt,
  output logic [31:0]       mem_cyc_cnt
`endif
);

  localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

  seq_state_t  state;
  logic [1:0]  lat_cnt;
  logic        is_store;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic        lane_misalign;

  // Upper data-address bits are deliberately dropped (wrap into the SRAM).
  logic        unused_addr_hi;
  assign unused_addr_hi = ^alu_out[31:ADDR_W+2];

  core_store_lane u_lane (
    .str_type (str_type),
    .a        (alu_out[1:0]),
    .wr_d     (mem_wr_d),
    .be       (lane_be),
    .wdata    (lane_wdata),
    .misalign (lane_misalign)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_RST;
      lat_cnt  <= '0;
      is_store <= 1'b0;
      instr    <= NOP_INSTR;
      mem_rd_d <= '0;
      vld      <= 1'b0;
      seq_err  <= 1'b0;
    end else begin
      vld <= 1'b0;
      case (state)
        S_RST: state <= S_F_REQ;
        S_F_REQ: begin
          lat_cnt <= LAT_M1;
          state   <= S_F_WAIT;
        end
        S_F_WAIT: begin
          if (lat_cnt == '0) begin
            instr <= m_rdata;
            state <= S_EXEC;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        S_EXEC: begin
          if (mem_wr) begin
            is_store <= 1'b1;
            if (mem_rd) seq_err <= 1'b1;
            state <= S_D_REQ;
          end else if (mem_rd) begin
            is_store <= 1'b0;
            state    <= S_D_REQ;
          end else begin
            vld   <= 1'b1;
            state <= S_COMMIT;
          end
        end
        S_D_REQ: begin
          if (is_store) begin
            if (lane_misalign) seq_err <= 1'b1;
            vld   <= 1'b1;
            state <= S_COMMIT;
          end else begin
            lat_cnt <= LAT_M1;
            state   <= S_D_WAIT;
          end
        end
        S_D_WAIT: begin
          if (lat_cnt == '0) begin
            mem_rd_d <= m_rdata;
            vld      <= 1'b1;
            state    <= S_COMMIT;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        S_COMMIT: state <= S_F_REQ;
        default:  state <= S_RST;
      endcase
    end
  end

  // SRAM port is decoded from the state register rather than registered:
  // the core only updates nxt_instr on the COMMIT edge, so the fetch address
  // must pass straight through in F_REQ. Reset forces state to S_RST
  // asynchronously, which drops m_req/m_we immediately.
  always_comb begin
    m_req   = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_be    = '0;
    case (state)
      S_F_REQ: begin
        m_req  = 1'b1;
        m_addr = nxt_instr;
      end
      S_D_REQ: begin
        if (!is_store) begin
          m_req  = 1'b1;
          m_addr = alu_out[ADDR_W+1:2];
        end else if (!lane_misalign) begin
          m_req   = 1'b1;
          m_we    = 1'b1;
          m_addr  = alu_out[ADDR_W+1:2];
          m_wdata = lane_wdata;
          m_be    = lane_be;
        end
      end
      default: ;
    endcase
  end

`ifdef CORE_MEM_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      instret_cnt <= '0;
      mem_cyc_cnt <= '0;
    end else begin
      if (state == S_COMMIT) instret_cnt <= instret_cnt + 32'd1;
      if (m_req)             mem_cyc_cnt <= mem_cyc_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_core_mem_seq.sv
// Scoreboard bench for core_mem_seq: stimulus pushes expected SRAM
// transactions and retire results into queues; independent monitors pop and
// compare on m_req and vld. A second instance with MEM_LAT=3 covers reset
// taken in the middle of a load.
module tb_core_mem_seq;

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rdd;
    int          gap;
    logic        err;
  } ret_exp_t;

  int tests = 0;
  int fails = 0;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rstn3 = 1'b0;
  logic [9:0]  nxt_instr = '0;
  logic [31:0] alu_out = '0;
  logic [31:0] mem_wr_d = '0;
  logic        mem_rd = 1'b0;
  logic        mem_wr = 1'b0;
  logic [1:0]  str_type = 2'b00;

  logic [31:0] instr, mem_rd_d, m_wdata, m_rdata;
  logic        vld, m_req, m_we, seq_err;
  logic [9:0]  m_addr;
  logic [3:0]  m_be;

  logic [31:0] instr3, mem_rd_d3, m_wdata3, m_rdata3;
  logic        vld3, m_req3, m_we3, seq_err3;
  logic [9:0]  m_addr3;
  logic [3:0]  m_be3;

`ifdef CORE_MEM_SEQ_PERF_EN
  logic [31:0] instret_cnt, mem_cyc_cnt, instret_cnt3, mem_cyc_cnt3;
`endif

  always #5 clk = ~clk;

  core_mem_seq #(.ADDR_W(10), .MEM_LAT(1)) dut (
    .clk(clk), .rstn(rstn), .nxt_instr(nxt_instr), .alu_out(alu_out),
    .mem_wr_d(mem_wr_d), .mem_rd(mem_rd), .mem_wr(mem_wr), .str_type(str_type),
    .instr(instr), .mem_rd_d(mem_rd_d), .vld(vld), .m_req(m_req), .m_we(m_we),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be), .m_rdata(m_rdata),
    .seq_err(seq_err)
`ifdef CORE_MEM_SEQ_PERF_EN
    , .instret_cnt(instret_cnt), .mem_cyc_cnt(mem_cyc_cnt)
`endif
  );

  core_mem_seq #(.ADDR_W(10), .MEM_LAT(3)) dut3 (
    .clk(clk), .rstn(rstn3), .nxt_instr(nxt_instr), .alu_out(alu_out),
    .mem_wr_d(mem_wr_d), .mem_rd(mem_rd), .mem_wr(mem_wr), .str_type(str_type),
    .instr(instr3), .mem_rd_d(mem_rd_d3), .vld(vld3), .m_req(m_req3), .m_we(m_we3),
    .m_addr(m_addr3), .m_wdata(m_wdata3), .m_be(m_be3), .m_rdata(m_rdata3),
    .seq_err(seq_err3)
`ifdef CORE_MEM_SEQ_PERF_EN
    , .instret_cnt(instret_cnt3), .mem_cyc_cnt(mem_cyc_cnt3)
`endif
  );

  // SRAM models: latency 1 with byte-enabled writes, and latency 3 read-only.
  logic [31:0] mem  [0:1023];
  logic [31:0] mem3 [0:1023];
  logic [31:0] rd1 = '0;
  logic [31:0] p1 = '0, p2 = '0, p3 = '0;

  always @(posedge clk) begin
    if (m_req) begin
      if (m_we) begin
        for (int b = 0; b < 4; b++)
          if (m_be[b]) mem[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
      end else begin
        rd1 <= mem[m_addr];
      end
    end
  end
  assign m_rdata = rd1;

  always @(posedge clk) begin
    if (m_req3 && !m_we3) p1 <= mem3[m_addr3];
    p2 <= p1;
    p3 <= p2;
  end
  assign m_rdata3 = p3;

  mem_exp_t mem_q[$];
  ret_exp_t ret_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // SRAM-side monitor
  always @(negedge clk) begin
    mem_exp_t e;
    if (!rstn) begin
      chk("no_req_in_reset", {31'd0, m_req}, 32'd0);
    end else if (m_req) begin
      if (mem_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_m_req: addr %0d we %b", m_addr, m_we);
      end else begin
        e = mem_q.pop_front();
        chk("m_we", {31'd0, m_we}, {31'd0, e.we});
        chk("m_addr", {22'd0, m_addr}, {22'd0, e.addr});
        if (e.we) begin
          chk("m_be", {28'd0, m_be}, {28'd0, e.be});
          chk("m_wdata", m_wdata, e.wdata);
        end
      end
    end else begin
      chk("idle_zero", {31'd0, (m_we || m_addr != '0 || m_wdata != '0 || m_be != '0)}, 32'd0);
    end
  end

  // Retire monitor
  int cyc = 0;
  int last_vld = 0;
  always @(negedge clk) begin
    ret_exp_t r;
    if (!rstn) begin
      cyc = 0;
      last_vld = 0;
    end else begin
      cyc++;
      if (vld) begin
        if (ret_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_vld: at cycle %0d", cyc);
        end else begin
          r = ret_q.pop_front();
          chk("instr", instr, r.instr);
          chk("mem_rd_d", mem_rd_d, r.rdd);
          chk("vld_gap", cyc - last_vld, r.gap);
          chk("seq_err", {31'd0, seq_err}, {31'd0, r.err});
        end
        last_vld = cyc;
      end
    end
  end

  task automatic issue(input logic [9:0] nxt, input logic rd, input logic wr,
                       input logic [1:0] st, input logic [31:0] alu, input logic [31:0] wd,
                       input logic dacc, input logic [3:0] e_be, input logic [31:0] e_wd,
                       input logic [31:0] e_instr, input logic [31:0] e_rdd,
                       input int e_gap, input logic e_err);
    mem_q.push_back('{we: 1'b0, addr: nxt, be: 4'h0, wdata: 32'h0});
    if (dacc) mem_q.push_back('{we: wr, addr: alu[11:2], be: e_be, wdata: e_wd});
    ret_q.push_back('{instr: e_instr, rdd: e_rdd, gap: e_gap, err: e_err});
    nxt_instr = nxt; mem_rd = rd; mem_wr = wr; str_type = st; alu_out = alu; mem_wr_d = wd;
  endtask

  task automatic wait_vld();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!vld && n < 20);
    if (!vld) begin
      tests++; fails++;
      $display("FAIL vld_timeout: got none expected within 20 cycles");
    end
    #1;
  endtask

  task automatic chk_reset_dut();
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_mem_rd_d", mem_rd_d, 32'h0);
    chk("rst_ctrl", {28'd0, vld, m_req, m_we, seq_err}, 32'h0);
    chk("rst_port", {12'd0, m_addr, m_be, (m_wdata != '0)}, 32'h0);
`ifdef CORE_MEM_SEQ_PERF_EN
    chk("rst_instret", instret_cnt, 32'h0);
    chk("rst_mem_cyc", mem_cyc_cnt, 32'h0);
`endif
  endtask

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = '0;
      mem3[i] = '0;
    end
    mem[5]  = 32'h0050_0093; mem[6]  = 32'h00A0_0113; mem[7]  = 32'h0FF0_0193;
    mem[8]  = 32'h1000_2203; mem[9]  = 32'h0041_1123; mem[10] = 32'h00C0_2823;
    mem[11] = 32'h0051_00A3; mem[12] = 32'h0061_2123; mem[13] = 32'h1080_2283;
    mem[64] = 32'h1122_3344; mem[66] = 32'hDEAD_BEEF;
    mem3[5] = 32'h0050_0093; mem3[66] = 32'hCAFE_F00D;

    #12;
    chk_reset_dut();

    // Group A: nop, load, byte store, load-back, half store, rd+wr word store
    issue(10'd5, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0,
          32'h0050_0093, 32'h0, 4, 1'b0);
    @(negedge clk); #1 rstn = 1'b1;
    wait_vld();
    issue(10'd6, 1'b1, 1'b0, 2'b00, 32'h0000_0108, 32'h0, 1'b1, 4'h0, 32'h0,
          32'h00A0_0113, 32'hDEAD_BEEF, 6, 1'b0);
    wait_vld();
    issue(10'd7, 1'b0, 1'b1, 2'b00, 32'h0000_0103, 32'h0000_00A5, 1'b1, 4'b1000, 32'hA5A5_A5A5,
          32'h0FF0_0193, 32'hDEAD_BEEF, 5, 1'b0);
    wait_vld();
    issue(10'd8, 1'b1, 1'b0, 2'b00, 32'h0000_0100, 32'h0, 1'b1, 4'h0, 32'h0,
          32'h1000_2203, 32'hA522_3344, 6, 1'b0);
    wait_vld();
    issue(10'd9, 1'b0, 1'b1, 2'b01, 32'h0000_0102, 32'h1234_BEEF, 1'b1, 4'b1100, 32'hBEEF_BEEF,
          32'h0041_1123, 32'hA522_3344, 5, 1'b0);
    wait_vld();
    issue(10'd10, 1'b1, 1'b1, 2'b10, 32'h0000_0010, 32'h1234_5678, 1'b1, 4'b1111, 32'h1234_5678,
          32'h00C0_2823, 32'hA522_3344, 5, 1'b1);
    wait_vld();
`ifdef CORE_MEM_SEQ_PERF_EN
    chk("instret_run", instret_cnt, 32'd5);
    chk("mem_cyc_run", mem_cyc_cnt, 32'd11);
`endif
    chk("sram_64", mem[64], 32'hBEEF_3344);
    chk("sram_4", mem[4], 32'h1234_5678);

    // Group B after reset: misaligned half, misaligned word, wrapped load
    rstn = 1'b0;
    #1 chk_reset_dut();
    issue(10'd11, 1'b0, 1'b1, 2'b01, 32'h0000_0101, 32'h0000_7777, 1'b0, 4'h0, 32'h0,
          32'h0051_00A3, 32'h0, 5, 1'b1);
    @(negedge clk); #1 rstn = 1'b1;
    wait_vld();
    issue(10'd12, 1'b0, 1'b1, 2'b10, 32'h0000_0202, 32'h5555_AAAA, 1'b0, 4'h0, 32'h0,
          32'h0061_2123, 32'h0, 5, 1'b1);
    wait_vld();
    issue(10'd13, 1'b1, 1'b0, 2'b00, 32'hFFFF_F108, 32'h0, 1'b1, 4'h0, 32'h0,
          32'h1080_2283, 32'hDEAD_BEEF, 6, 1'b1);
    wait_vld();
    chk("sram_64_unchanged", mem[64], 32'hBEEF_3344);
    chk("sram_128_unchanged", mem[128], 32'h0);
    rstn = 1'b0;

    // MEM_LAT=3 instance: reset while waiting on load data
    nxt_instr = 10'd5; mem_rd = 1'b1; mem_wr = 1'b0; alu_out = 32'h0000_0108;
    @(negedge clk); #1 rstn3 = 1'b1;
    n = 0;
    for (int k = 0; k < 30 && n < 2; k++) begin
      @(negedge clk);
      if (m_req3) n++;
    end
    chk("lat3_reqs_seen", n, 2);
    @(negedge clk);
    chk("lat3_instr_fetched", instr3, 32'h0050_0093);
    #2 rstn3 = 1'b0;
    #1;
    chk("lat3_rst_ctrl", {28'd0, vld3, m_req3, m_we3, seq_err3}, 32'h0);
    chk("lat3_rst_port", {12'd0, m_addr3, m_be3, (m_wdata3 != '0)}, 32'h0);
    chk("lat3_rst_instr", instr3, 32'h0000_0013);
    chk("lat3_rst_rdd", mem_rd_d3, 32'h0);
`ifdef CORE_MEM_SEQ_PERF_EN
    chk("lat3_rst_instret", instret_cnt3, 32'h0);
    chk("lat3_rst_mem_cyc", mem_cyc_cnt3, 32'h0);
`endif
    @(negedge clk); #1 rstn3 = 1'b1;
    #1 chk("lat3_no_req_at_release", {31'd0, m_req3}, 32'd0);
    @(negedge clk);
    chk("lat3_first_freq", {31'd0, m_req3}, 32'd1);
    chk("lat3_first_faddr", {22'd0, m_addr3}, 32'd5);

    chk("mem_q_empty", mem_q.size(), 32'd0);
    chk("ret_q_empty", ret_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
